conv2d_stream_param: RTL and testbench
======================================

# conv2d_stream_param

Parametrised 2-D valid-mode convolution engine for the Lab03 convolution datapath. It receives an N×N input feature map (IFM) and a K×K kernel as raster-order word streams, then computes every output window. The computation runs through a two-stage multiply/add pipeline, and the block streams the M×M output feature map (OFM) back-to-back, one word per cycle. It generalises the fixed 7×7 / 3×3 engine in three ways: configurable sizes, configurable stride, and kernel retention across frames.

## Interface
- DW, 16, IFM and weight word width (unsigned)
- IFM_N, 7, IFM side length N (N ≥ K)
- K, 3, kernel side length (K ≥ 1)
- STRIDE, 1, window step S ∈ {1,2}; (N−K) must be divisible by S
- Derived: M = (N−K)/S + 1; OW = 2·DW + clog2(K·K); defaults give M=5, OW=36
- clk  input  1  single clock, rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- in_valid  input  1  IFM word strobe
- in_ifm  input  DW  IFM word, raster order (row-major)
- weight_valid  input  1  kernel word strobe
- in_weight  input  DW  kernel word, raster order
- out_valid  output  1  OFM word valid (registered)
- out_ofm  output  OW  OFM word, raster order (registered)
- busy  output  1  high from the first accepted IFM word until the last OFM word (registered)

## Operation
- Storage:
  - IFM buffer: N×N × DW.
  - Kernel buffer: K×K × DW.
  - Product register stage: K·K × 2DW.
  - Sum register: OW.
- Arithmetic: unsigned. OFM(r,c) = Σ IFM[r·S+i][c·S+j]·W[i][j] over i,j < K. OW guarantees no overflow. No truncation or saturation.
- Kernel load:
  - Each weight_valid cycle writes W at the weight index. The index increments and wraps from K·K−1 to 0.
  - The index clears on any cycle with weight_valid low.
  - Words are accepted only in IDLE and LOAD; weight_valid is ignored in COMP.
  - Kernel contents persist across frames until overwritten. A frame without weight_valid reuses the previous kernel. After reset the kernel is all zero.
- FSM states: IDLE, LOAD, COMP.
- IDLE → LOAD: on in_valid. That word is stored at index 0 and busy goes high.
- LOAD: each in_valid cycle stores the next word.
  - When word N·N−1 is stored, go to COMP.
  - If in_valid is low before N·N words have arrived, abort: return to IDLE, clear the IFM index and busy, produce no output. Buffer contents are don't-care.
- COMP: issues one window per cycle in raster order, (0,0) through (M−1,M−1), for exactly M·M cycles.
  - in_valid is ignored throughout COMP.
  - After the final issue, the pipeline drains. The state returns to IDLE once the last OFM word has been registered.
- Output: out_ofm equals the window sum when out_valid is 1, and 0 otherwise.

## Timing
- All outputs reset to 0. This includes out_valid, out_ofm and busy, plus the FSM (to IDLE), all counters, the pipeline registers and both buffers.
- Let E0 be the edge that samples the last IFM word.
  - Window 0 products register at E1, its sum registers at E2, and out_valid/out_ofm register at E3.
  - Latency is therefore 3 cycles from the last IFM word to the first OFM word.
- out_valid stays high for exactly M·M consecutive cycles with no bubbles.
- busy falls on the same edge that clears out_valid after the last word.
- The next frame's in_valid is accepted on the first cycle in which busy is low. Full back-to-back frame spacing is N·N + M·M + 3 cycles.
- Simultaneous in_valid and weight_valid in LOAD are both accepted. This also applies in IDLE, where the two may start a frame and a kernel load on the same cycle. The kernel must be complete before E0; otherwise the partially written kernel is used as-is.
- Reset mid-operation (any state) clears everything immediately. out_valid drops asynchronously and no further output appears.

## Test plan
- Default parameters, kernel all 1, IFM all 1 → 25 OFM words of 9. The first arrives exactly 3 cycles after the 49th IFM word, with 25 contiguous out_valid cycles, after which busy drops.
- Defaults, IFM[r][c] = 7r+c, W = identity-centre (W[1][1]=1, others 0) → OFM(r,c) = 7(r+1)+(c+1), i.e. 8, 9, …, 12, 15, …, 40.
- Defaults, all IFM and weights 0xFFFF → every OFM = 9·0xFFFE0001 = 0x8FFEE0009, with no wrap in the 36-bit output.
- STRIDE=2, N=7, K=3 → M=3, 9 outputs. All-ones input gives 9 each. With the ramp IFM and centre kernel, outputs are 8, 10, 12, 22, 24, 26, 36, 38, 40.
- Kernel retention and abort:
  - Frame 1: load kernel and IFM.
  - Frame 2: IFM only → results computed with the frame-1 kernel.
  - Then drop in_valid after 20 words → no out_valid, busy falls, and a following full frame computes correctly.
- Assert rst_n low during OFM word 10 → out_valid, out_ofm and busy are 0 immediately. A fresh kernel and IFM load after release produces a correct 25-word frame.

Source files
------------

// File: rtl/conv2d_stream_param_if.sv
// Stream bus between an IFM/kernel source and the 2-D convolution engine.
interface conv2d_stream_param_if #(
   parameter int DW = 16,
   parameter int OW = 36
) ();
   logic          in_valid;
   logic [DW-1:0] in_ifm;
   logic          weight_valid;
   logic [DW-1:0] in_weight;
   logic          out_valid;
   logic [OW-1:0] out_ofm;
   logic          busy;

   modport master (
      output in_valid, in_ifm, weight_valid, in_weight,
      input  out_valid, out_ofm, busy
   );

   modport slave (
      input  in_valid, in_ifm, weight_valid, in_weight,
      output out_valid, out_ofm, busy
   );
endinterface

// File: rtl/conv2d_stream_param.sv
// Parametrised valid-mode 2-D convolution: buffers an N x N IFM and a K x K
// kernel, then streams the M x M OFM through a product stage and a sum stage.
module conv2d_stream_param #(
   parameter int DW     = 16,
   parameter int IFM_N  = 7,
   parameter int K      = 3,
   parameter int STRIDE = 1
) (
   input logic                  clk,
   input logic                  rst_n,
   conv2d_stream_param_if.slave bus
);
   localparam int M  = (IFM_N - K) / STRIDE + 1;
   localparam int NN = IFM_N * IFM_N;
   localparam int KK = K * K;
   localparam int PW = 2 * DW;
   localparam int OW = 2 * DW + $clog2(KK);
   localparam int IA = (NN > 1) ? $clog2(NN) : 1;
   localparam int WA = (KK > 1) ? $clog2(KK) : 1;
   localparam int RW = (M > 1) ? $clog2(M) : 1;

   typedef enum logic [1:0] {IDLE, LOAD, COMP} state_t;

   state_t        state;
   logic [DW-1:0] ifm_mem  [NN];
   logic [DW-1:0] w_mem    [KK];
   logic [IA-1:0] ifm_idx;
   logic [WA-1:0] w_idx;
   logic [RW-1:0] win_r;
   logic [RW-1:0] win_c;
   logic          issue_done;
   logic          issuing;
   logic [IA-1:0] addr;
   logic [PW-1:0] win_prod [KK];
   logic [PW-1:0] prod_q   [KK];
   logic          p_valid;
   logic [OW-1:0] prod_sum;
   logic [OW-1:0] sum_q;
   logic          s_valid;
   logic          busy_q;
   logic          out_valid_q;
   logic [OW-1:0] out_ofm_q;

   assign bus.busy      = busy_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_ofm   = out_ofm_q;

   // A window is issued every COMP cycle until the last one has gone out.
   assign issuing = (state == COMP) && !issue_done;

   // Kernel load: write at a running index that wraps, clears whenever the strobe drops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_idx <= '0;
         // NOTE: both buffers are reset on purpose: a frame sent without a kernel after reset must see zero weights, and a reset mid-frame must leave nothing behind.
         for (int k = 0; k < KK; k++) w_mem[k] <= '0;
      end else if (!bus.weight_valid) begin
         w_idx <= '0;
      end else if (state != COMP) begin
         w_mem[w_idx] <= bus.in_weight;
         w_idx        <= (w_idx == WA'(KK - 1)) ? '0 : w_idx + 1'b1;
      end
   end

   // IFM capture: each accepted word lands at the current raster index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NN; k++) ifm_mem[k] <= '0;
      end else if (state != COMP && bus.in_valid) begin
         ifm_mem[ifm_idx] <= bus.in_ifm;
      end
   end

   // Gather the current window from the IFM buffer and form its K*K products.
   always_comb begin
      // NOTE: every combinational output gets a default before the loops so no latch can be inferred.
      addr = '0;
      for (int k = 0; k < KK; k++) win_prod[k] = '0;
      for (int i = 0; i < K; i++) begin
         for (int j = 0; j < K; j++) begin
            addr = IA'((int'(win_r) * STRIDE + i) * IFM_N + int'(win_c) * STRIDE + j);
            win_prod[i * K + j] = PW'(ifm_mem[addr]) * PW'(w_mem[i * K + j]);
         end
      end
   end

   // Reduce the registered products to one window sum.
   always_comb begin
      // NOTE: the accumulator relies on blocking assignment so each iteration sees the previous partial sum.
      prod_sum = '0;
      for (int k = 0; k < KK; k++) prod_sum = prod_sum + OW'(prod_q[k]);
   end

   // Control FSM: IFM load with abort, raster window issue, then drain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         ifm_idx    <= '0;
         win_r      <= '0;
         win_c      <= '0;
         issue_done <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         case (state)
            IDLE, LOAD: begin
               if (bus.in_valid) begin
                  busy_q <= 1'b1;
                  if (ifm_idx == IA'(NN - 1)) begin
                     ifm_idx <= '0;
                     state   <= COMP;
                  end else begin
                     ifm_idx <= ifm_idx + 1'b1;
                     state   <= LOAD;
                  end
               end else if (state == LOAD) begin
                  ifm_idx <= '0;
                  busy_q  <= 1'b0;
                  state   <= IDLE;
               end
            end
            COMP: begin
               if (!issue_done) begin
                  if (win_c == RW'(M - 1)) begin
                     win_c <= '0;
                     if (win_r == RW'(M - 1)) begin
                        win_r      <= '0;
                        issue_done <= 1'b1;
                     end else begin
                        win_r <= win_r + 1'b1;
                     end
                  end else begin
                     win_c <= win_c + 1'b1;
                  end
               end else if (!p_valid && !s_valid) begin
                  // Last OFM word was registered on the previous edge.
                  issue_done <= 1'b0;
                  busy_q     <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Datapath pipeline: products, sum, then the zero-forced output register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < KK; k++) prod_q[k] <= '0;
         p_valid     <= 1'b0;
         sum_q       <= '0;
         s_valid     <= 1'b0;
         out_valid_q <= 1'b0;
         out_ofm_q   <= '0;
      end else begin
         p_valid <= issuing;
         if (issuing) begin
            for (int k = 0; k < KK; k++) prod_q[k] <= win_prod[k];
         end
         s_valid     <= p_valid;
         sum_q       <= prod_sum;
         out_valid_q <= s_valid;
         out_ofm_q   <= s_valid ? sum_q : '0;
      end
   end
endmodule

// File: tb/tb_conv2d_stream_param.sv
// Scoreboard bench for conv2d_stream_param: one stride-1 and one stride-2 instance.
module tb_conv2d_stream_param;
   localparam int DW = 16;
   localparam int OW = 36;
   localparam int N  = 7;
   localparam int KS = 3;
   localparam int NN = N * N;
   localparam int KK = KS * KS;

   logic clk;
   logic rst_n;
   int   vecs = 0;
   int   errs = 0;

   logic [DW-1:0] img [NN];
   logic [DW-1:0] ker [KK];
   logic [OW-1:0] ev  [25];
   logic [OW-1:0] q1  [$];
   logic [OW-1:0] q2  [$];

   conv2d_stream_param_if #(.DW(DW), .OW(OW)) b1 ();
   conv2d_stream_param_if #(.DW(DW), .OW(OW)) b2 ();

   conv2d_stream_param #(.DW(DW), .IFM_N(N), .K(KS), .STRIDE(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(b1));
   conv2d_stream_param #(.DW(DW), .IFM_N(N), .K(KS), .STRIDE(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .bus(b2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor for the stride-1 instance.
   always @(negedge clk) begin
      if (b1.out_valid === 1'b1) begin
         if (q1.size() == 0) begin
            vecs++;
            errs++;
            $display("FAIL dut1_unexpected_out: got %0h expected no output at %0t", b1.out_ofm, $time);
         end else begin
            check("dut1_ofm", 64'(b1.out_ofm), 64'(q1.pop_front()));
         end
      end else if (b1.out_ofm !== '0) begin
         vecs++;
         errs++;
         $display("FAIL dut1_idle_ofm: got %0h expected 0 at %0t", b1.out_ofm, $time);
      end
   end

   // Monitor for the stride-2 instance.
   always @(negedge clk) begin
      if (b2.out_valid === 1'b1) begin
         if (q2.size() == 0) begin
            vecs++;
            errs++;
            $display("FAIL dut2_unexpected_out: got %0h expected no output at %0t", b2.out_ofm, $time);
         end else begin
            check("dut2_ofm", 64'(b2.out_ofm), 64'(q2.pop_front()));
         end
      end else if (b2.out_ofm !== '0) begin
         vecs++;
         errs++;
         $display("FAIL dut2_idle_ofm: got %0h expected 0 at %0t", b2.out_ofm, $time);
      end
   end

   function automatic logic ov(input int sel);
      return (sel == 1) ? b1.out_valid : b2.out_valid;
   endfunction

   function automatic logic bz(input int sel);
      return (sel == 1) ? b1.busy : b2.busy;
   endfunction

   task automatic set_in(input int sel, input logic iv, input logic [DW-1:0] id,
                         input logic wv, input logic [DW-1:0] wd);
      if (sel == 1) begin
         b1.in_valid = iv; b1.in_ifm = id; b1.weight_valid = wv; b1.in_weight = wd;
      end else begin
         b2.in_valid = iv; b2.in_ifm = id; b2.weight_valid = wv; b2.in_weight = wd;
      end
   endtask

   // Streams nwords IFM words; with_k overlays the kernel on the first K*K cycles.
   // now=1 drives the first word at the current negedge instead of the next one.
   task automatic send_frame(input int sel, input bit with_k, input int nwords, input bit now);
      for (int i = 0; i < nwords; i++) begin
         if (!(now && i == 0)) @(negedge clk);
         set_in(sel, 1'b1, img[i], with_k && i < KK, (with_k && i < KK) ? ker[i] : '0);
      end
      @(negedge clk);
      set_in(sel, 1'b0, '0, 1'b0, '0);
   endtask

   task automatic load_kernel(input int sel);
      for (int i = 0; i < KK; i++) begin
         @(negedge clk);
         set_in(sel, 1'b0, '0, 1'b1, ker[i]);
      end
      @(negedge clk);
      set_in(sel, 1'b0, '0, 1'b0, '0);
   endtask

   // Called right after send_frame: checks 3-cycle latency, run length and busy drop.
   task automatic check_timing(input int sel, input int m, input string tag);
      int cnt;
      check({tag, "_busy_in_comp"}, 64'(bz(sel)), 64'd1);
      @(negedge clk);
      @(negedge clk);
      check({tag, "_no_early_out"}, 64'(ov(sel)), 64'd0);
      @(negedge clk);
      check({tag, "_first_out_lat3"}, 64'(ov(sel)), 64'd1);
      cnt = 0;
      while (ov(sel) === 1'b1 && cnt < 1000) begin
         cnt++;
         @(negedge clk);
      end
      check({tag, "_valid_run"}, 64'(cnt), 64'(m * m));
      check({tag, "_busy_drop"}, 64'(bz(sel)), 64'd0);
   endtask

   task automatic push_exp(input int sel, input int cnt);
      for (int i = 0; i < cnt; i++) begin
         if (sel == 1) q1.push_back(ev[i]);
         else          q2.push_back(ev[i]);
      end
   endtask

   task automatic fill_img(input int kind);
      for (int i = 0; i < NN; i++) begin
         case (kind)
            0:       img[i] = 16'd1;
            1:       img[i] = DW'(i);
            default: img[i] = 16'hFFFF;
         endcase
      end
   endtask

   task automatic set_ker_single(input int pos);
      for (int i = 0; i < KK; i++) ker[i] = (i == pos) ? 16'd1 : 16'd0;
   endtask

   task automatic set_ev_const(input logic [OW-1:0] v);
      for (int i = 0; i < 25; i++) ev[i] = v;
   endtask

   // Ramp IFM (7r+c) with the centre kernel: OFM(r,c) = 7(r+1)+(c+1).
   task automatic set_ev_centre();
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < 5; c++) ev[r * 5 + c] = OW'(7 * (r + 1) + (c + 1));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      set_in(1, 1'b0, '0, 1'b0, '0);
      set_in(2, 1'b0, '0, 1'b0, '0);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_out_valid", 64'(b1.out_valid), 64'd0);
      check("rst_out_ofm",   64'(b1.out_ofm),   64'd0);
      check("rst_busy",      64'(b1.busy),      64'd0);
      check("rst2_out_valid", 64'(b2.out_valid), 64'd0);
      check("rst2_busy",      64'(b2.busy),      64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Kernel is all zero after reset.
      fill_img(0);
      set_ev_const('0);
      push_exp(1, 25);
      send_frame(1, 1'b0, NN, 1'b0);
      check_timing(1, 5, "zero_kernel");

      // All ones, kernel loaded alongside the IFM, started on the first non-busy cycle.
      for (int i = 0; i < KK; i++) ker[i] = 16'd1;
      set_ev_const(36'd9);
      push_exp(1, 25);
      send_frame(1, 1'b1, NN, 1'b1);
      check_timing(1, 5, "ones");

      // Ramp IFM, centre kernel loaded alone in IDLE.
      fill_img(1);
      set_ker_single(4);
      load_kernel(1);
      set_ev_centre();
      push_exp(1, 25);
      send_frame(1, 1'b0, NN, 1'b0);
      check_timing(1, 5, "ramp_centre");

      // Ramp IFM, top-right kernel tap: OFM = 7r+c+2.
      set_ker_single(2);
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < 5; c++) ev[r * 5 + c] = OW'(7 * r + c + 2);
      push_exp(1, 25);
      send_frame(1, 1'b1, NN, 1'b0);
      check_timing(1, 5, "ramp_topright");

      // Ramp IFM, bottom-left kernel tap: OFM = 7(r+2)+c.
      set_ker_single(6);
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < 5; c++) ev[r * 5 + c] = OW'(7 * (r + 2) + c);
      push_exp(1, 25);
      send_frame(1, 1'b1, NN, 1'b0);
      check_timing(1, 5, "ramp_bottomleft");

      // Full-scale operands: 9 * 0xFFFE0001 with no wrap.
      fill_img(2);
      for (int i = 0; i < KK; i++) ker[i] = 16'hFFFF;
      set_ev_const(36'h8FFEE0009);
      push_exp(1, 25);
      send_frame(1, 1'b1, NN, 1'b0);
      check_timing(1, 5, "max_operands");

      // Retention: frame 1 loads centre kernel, frame 2 reuses it.
      fill_img(1);
      set_ker_single(4);
      set_ev_centre();
      push_exp(1, 25);
      send_frame(1, 1'b1, NN, 1'b0);
      check_timing(1, 5, "retain_f1");
      fill_img(0);
      set_ev_const(36'd1);
      push_exp(1, 25);
      send_frame(1, 1'b0, NN, 1'b0);
      check_timing(1, 5, "retain_f2");

      // Abort after 20 words: no output, busy falls.
      send_frame(1, 1'b0, 20, 1'b0);
      check("abort_busy_before", 64'(b1.busy), 64'd1);
      @(negedge clk);
      check("abort_busy_drop", 64'(b1.busy), 64'd0);
      repeat (10) @(negedge clk);
      check("abort_no_out", 64'(b1.out_valid), 64'd0);

      // Full frame after abort, kernel still retained.
      fill_img(1);
      set_ev_centre();
      push_exp(1, 25);
      send_frame(1, 1'b0, NN, 1'b0);
      check_timing(1, 5, "after_abort");

      // Reset during OFM streaming.
      fill_img(0);
      for (int i = 0; i < KK; i++) ker[i] = 16'd1;
      set_ev_const(36'd9);
      push_exp(1, 25);
      send_frame(1, 1'b1, NN, 1'b0);
      repeat (3) @(negedge clk);
      repeat (10) @(negedge clk);
      check("midrst_streaming", 64'(b1.out_valid), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_out_valid", 64'(b1.out_valid), 64'd0);
      check("midrst_out_ofm",   64'(b1.out_ofm),   64'd0);
      check("midrst_busy",      64'(b1.busy),      64'd0);
      q1.delete();
      @(negedge clk);
      rst_n = 1'b1;
      fill_img(1);
      set_ker_single(4);
      set_ev_centre();
      push_exp(1, 25);
      send_frame(1, 1'b1, NN, 1'b0);
      check_timing(1, 5, "post_reset");

      // Stride 2: all ones gives 9 per window.
      fill_img(0);
      for (int i = 0; i < KK; i++) ker[i] = 16'd1;
      set_ev_const(36'd9);
      push_exp(2, 9);
      send_frame(2, 1'b1, NN, 1'b0);
      check_timing(2, 3, "s2_ones");

      // Stride 2: ramp with centre kernel.
      fill_img(1);
      set_ker_single(4);
      ev[0] = 36'd8;  ev[1] = 36'd10; ev[2] = 36'd12;
      ev[3] = 36'd22; ev[4] = 36'd24; ev[5] = 36'd26;
      ev[6] = 36'd36; ev[7] = 36'd38; ev[8] = 36'd40;
      push_exp(2, 9);
      send_frame(2, 1'b1, NN, 1'b0);
      check_timing(2, 3, "s2_ramp_centre");

      repeat (5) @(negedge clk);
      check("dut1_queue_drained", 64'(q1.size()), 64'd0);
      check("dut2_queue_drained", 64'(q2.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
